cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the RV32I core datapath. It issues instruction fetches and data-memory accesses over req/ack handshakes, gates the instruction decoder's `writeReg`/`writeRam` outputs into single-cycle commit strobes, and advances the PC once per retired instruction. It sits between the instruction/data memory ports and the decoder + register file. It also counts retired instructions and halts on illegal opcodes or memory timeouts.

---
 rtl/cpu_sequencer.sv | 168 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch/exec/mem/wb over req/ack handshakes, commit strobes, retire count.
// Latency: ALU/branch 2 cycles, store 3, load 4, plus one cycle per memory wait cycle.
// Backpressure: req is held until ack; TIMEOUT unacked req cycles or an illegal opcode halt the core.
module cpu_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic [4:0]       opcode,
    input  logic             decWriteReg,
    input  logic             decWriteRam,
    input  logic             decBranch,
    output logic             imemReq,
    input  logic             imemAck,
    output logic             dmemReq,
    output logic             dmemWe,
    input  logic             dmemAck,
    output logic             irWrite,
    output logic             pcWrite,
    output logic             regWrite,
    output logic [2:0]       state,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_ALUI   = 5'b00100;
    localparam logic [4:0] OP_ALU    = 5'b01100;

    localparam logic [1:0] F_NONE  = 2'b00;
    localparam logic [1:0] F_FETCH = 2'b01;
    localparam logic [1:0] F_DATA  = 2'b10;
    localparam logic [1:0] F_ILL   = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [1:0]        fault_q, fault_d;
    logic [CNT_W-1:0]  retired_q;
    logic              legal;
    logic              imem_req, dmem_req, dmem_we, ir_w, pc_w, reg_w, halt;

    // Branch target selection lives in the datapath; the flag is not needed here.
    logic unused_branch;
    assign unused_branch = decBranch;

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_ALUI, OP_ALU: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            fault_q   <= F_NONE;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            if (pc_w) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // wait_d defaults to zero so every state change clears the counter.
    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        fault_d  = fault_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_w     = 1'b0;
        pc_w     = 1'b0;
        reg_w    = 1'b0;
        halt     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imemAck) begin
                    ir_w    = 1'b1;
                    state_d = S_EXEC;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    fault_d = F_FETCH;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_EXEC: begin
                if (!legal) begin
                    state_d = S_HALT;
                    fault_d = F_ILL;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d = S_MEM;
                end else begin
                    pc_w    = 1'b1;
                    reg_w   = decWriteReg;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = decWriteRam;
                if (dmemAck) begin
                    if (opcode == OP_STORE) begin
                        pc_w    = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    fault_d = F_DATA;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                reg_w   = 1'b1;
                pc_w    = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halt = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Everything reads zero while reset is held, including the fetch request.
    assign imemReq  = nReset & imem_req;
    assign dmemReq  = nReset & dmem_req;
    assign dmemWe   = nReset & dmem_we;
    assign irWrite  = nReset & ir_w;
    assign pcWrite  = nReset & pc_w;
    assign regWrite = nReset & reg_w;
    assign halted   = nReset & halt;
    assign state    = nReset ? state_q : 3'd0;
    assign fault    = nReset ? fault_q : F_NONE;
    assign retired  = nReset ? retired_q : '0;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with TIMEOUT=15 and a 4-bit retire counter.
// Per-cycle expected output vectors are queued as each step is driven and compared at the falling edge.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic [4:0] opcode = 5'b01100;
    logic       decWriteReg = 1'b0;
    logic       decWriteRam = 1'b0;
    logic       decBranch = 1'b0;
    logic       imemAck = 1'b0;
    logic       dmemAck = 1'b0;
    logic       imemReq, dmemReq, dmemWe, irWrite, pcWrite, regWrite, halted;
    logic [2:0] state;
    logic [1:0] fault;
    logic [3:0] retired;

    int passed = 0;
    int total  = 0;
    logic [11:0] exp_q[$];

    cpu_sequencer #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .nReset(nReset), .opcode(opcode),
        .decWriteReg(decWriteReg), .decWriteRam(decWriteRam), .decBranch(decBranch),
        .imemReq(imemReq), .imemAck(imemAck), .dmemReq(dmemReq), .dmemWe(dmemWe),
        .dmemAck(dmemAck), .irWrite(irWrite), .pcWrite(pcWrite), .regWrite(regWrite),
        .state(state), .halted(halted), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    // {state, imemReq, irWrite, dmemReq, dmemWe, pcWrite, regWrite, halted, fault}
    function automatic logic [11:0] mk(input logic [2:0] st, input logic ireq, input logic irw,
                                       input logic dreq, input logic dwe, input logic pcw,
                                       input logic rgw, input logic hlt, input logic [1:0] flt);
        return {st, ireq, irw, dreq, dwe, pcw, rgw, hlt, flt};
    endfunction

    task automatic step(input string tag, input logic ia, input logic da, input logic rn,
                        input logic [11:0] expv);
        logic [11:0] got, want;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        imemAck = ia;
        dmemAck = da;
        nReset  = rn;
        @(negedge clk);
        got  = {state, imemReq, irWrite, dmemReq, dmemWe, pcWrite, regWrite, halted, fault};
        want = exp_q.pop_front();
        total++;
        assert (got === want) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic chk_ret(input string tag, input logic [3:0] want);
        total++;
        assert (retired === want) begin
            passed++;
        end else begin
            $error("FAIL %s: observed retired %0d expected %0d", tag, retired, want);
        end
    endtask

    task automatic set_instr(input logic [4:0] op, input logic rg, input logic rm);
        opcode      = op;
        decWriteReg = rg;
        decWriteRam = rm;
    endtask

    localparam logic [11:0] ZERO = 12'h000;

    initial begin
        logic [11:0] f_wait, f_ack, ex_none, mem_rd, mem_wr, halt_v;
        f_wait  = mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 2'b00);
        f_ack   = mk(3'd0, 1, 1, 0, 0, 0, 0, 0, 2'b00);
        ex_none = mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        mem_rd  = mk(3'd2, 0, 0, 1, 0, 0, 0, 0, 2'b00);
        mem_wr  = mk(3'd2, 0, 0, 1, 1, 0, 0, 0, 2'b00);

        // Reset: all outputs zero even with acks asserted
        step("reset0", 1, 1, 0, ZERO);
        step("reset1", 1, 1, 0, ZERO);
        chk_ret("reset_retired", 4'd0);

        // ADD with imemAck tied high
        set_instr(5'b01100, 1, 0);
        step("add_fetch", 1, 0, 1, f_ack);
        step("add_exec", 1, 0, 1, mk(3'd1, 0, 0, 0, 0, 1, 1, 0, 2'b00));
        step("add_next", 0, 0, 1, f_wait);
        chk_ret("add_retired", 4'd1);
        step("rst_a", 0, 0, 0, ZERO);

        // Load with dmemAck delayed 3 cycles: 7 cycles total
        set_instr(5'b00000, 1, 0);
        step("ld_fetch", 1, 0, 1, f_ack);
        step("ld_exec", 0, 0, 1, ex_none);
        for (int i = 0; i < 3; i++) step("ld_memwait", 0, 0, 1, mem_rd);
        step("ld_memack", 0, 1, 1, mem_rd);
        step("ld_wb", 0, 0, 1, mk(3'd3, 0, 0, 0, 0, 1, 1, 0, 2'b00));
        step("ld_next", 0, 0, 1, f_wait);
        chk_ret("ld_retired", 4'd1);
        step("rst_b", 0, 0, 0, ZERO);

        // Store: dmemWe with dmemReq, pcWrite in ack cycle, regWrite never
        set_instr(5'b01000, 1, 1);
        step("st_fetch", 1, 0, 1, f_ack);
        step("st_exec", 0, 0, 1, ex_none);
        step("st_memwait", 0, 0, 1, mem_wr);
        step("st_memack", 0, 1, 1, mk(3'd2, 0, 0, 1, 1, 1, 0, 0, 2'b00));
        step("st_next", 0, 0, 1, f_wait);
        chk_ret("st_retired", 4'd1);

        // Reset in the middle of a load abandons it
        set_instr(5'b00000, 1, 0);
        step("ab_fetch", 1, 0, 1, f_ack);
        step("ab_exec", 0, 0, 1, ex_none);
        step("ab_mem", 0, 0, 1, mem_rd);
        step("ab_reset", 0, 1, 0, ZERO);
        step("ab_next", 0, 0, 1, f_wait);
        chk_ret("ab_retired", 4'd0);
        step("rst_c", 0, 0, 0, ZERO);

        // Illegal opcode halts with fault 11; stray acks ignored for 20 cycles
        set_instr(5'b11111, 1, 1);
        halt_v = mk(3'd4, 0, 0, 0, 0, 0, 0, 1, 2'b11);
        step("ill_fetch", 1, 0, 1, f_ack);
        step("ill_exec", 1, 1, 1, ex_none);
        for (int i = 0; i < 20; i++) step("ill_halt", 1, 1, 1, halt_v);
        chk_ret("ill_retired", 4'd0);
        step("ill_reset", 0, 0, 0, ZERO);
        step("ill_refetch", 0, 0, 1, f_wait);

        // Fetch timeout after exactly 15 request cycles
        step("rst_d", 0, 0, 0, ZERO);
        set_instr(5'b01100, 1, 0);
        for (int i = 0; i < 15; i++) step("fto_wait", 0, 0, 1, f_wait);
        step("fto_halt", 0, 0, 1, mk(3'd4, 0, 0, 0, 0, 0, 0, 1, 2'b01));
        step("fto_hold", 1, 0, 1, mk(3'd4, 0, 0, 0, 0, 0, 0, 1, 2'b01));

        // Fetch ack on the 15th cycle completes normally
        step("rst_e", 0, 0, 0, ZERO);
        for (int i = 0; i < 14; i++) step("fok_wait", 0, 0, 1, f_wait);
        step("fok_ack", 1, 0, 1, f_ack);
        step("fok_exec", 0, 0, 1, mk(3'd1, 0, 0, 0, 0, 1, 1, 0, 2'b00));
        step("fok_next", 0, 0, 1, f_wait);
        chk_ret("fok_retired", 4'd1);

        // Data timeout after 15 MEM request cycles
        step("rst_f", 0, 0, 0, ZERO);
        set_instr(5'b00000, 1, 0);
        step("dto_fetch", 1, 0, 1, f_ack);
        step("dto_exec", 0, 0, 1, ex_none);
        for (int i = 0; i < 15; i++) step("dto_wait", 0, 0, 1, mem_rd);
        step("dto_halt", 0, 1, 1, mk(3'd4, 0, 0, 0, 0, 0, 0, 1, 2'b10));
        chk_ret("dto_retired", 4'd0);

        // Store acked on the 15th MEM cycle completes normally
        step("rst_g", 0, 0, 0, ZERO);
        set_instr(5'b01000, 0, 1);
        step("dok_fetch", 1, 0, 1, f_ack);
        step("dok_exec", 0, 0, 1, ex_none);
        for (int i = 0; i < 14; i++) step("dok_wait", 0, 0, 1, mem_wr);
        step("dok_ack", 0, 1, 1, mk(3'd2, 0, 0, 1, 1, 1, 0, 0, 2'b00));
        step("dok_next", 0, 0, 1, f_wait);
        chk_ret("dok_retired", 4'd1);

        // 16 back-to-back ADDs wrap the 4-bit counter; stray dmemAck in FETCH
        step("rst_h", 0, 0, 0, ZERO);
        set_instr(5'b01100, 1, 0);
        for (int i = 0; i < 16; i++) begin
            step("wrap_fetch", 1, 1, 1, f_ack);
            chk_ret("wrap_count", 4'(i));
            step("wrap_exec", 1, 0, 1, mk(3'd1, 0, 0, 0, 0, 1, 1, 0, 2'b00));
        end
        step("wrap_end", 0, 1, 1, f_wait);
        chk_ret("wrap_zero", 4'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
